// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset release sequencer.
//   state_t   : sequencer FSM encoding (HOLD / RELEASE / RUN)
//   CAUSE_*   : reset-cause encodings reported on RST_CAUSE
//   SW_CNT_W  : width of the software reset counter
package rst_seq_pkg;

  typedef enum logic [1:0] {
    S_HOLD    = 2'd0,
    S_RELEASE = 2'd1,
    S_RUN     = 2'd2
  } state_t;

  localparam logic CAUSE_POR = 1'b0;
  localparam logic CAUSE_SW  = 1'b1;

  localparam int unsigned SW_CNT_W = 8;

endpackage

// File: rtl/rst_seq_timer.sv
// Interval timer for the reset sequencer.
// Up-counter with synchronous clear and enable. o_tc flags the cycle in which
// the count equals the runtime limit, so an interval of N cycles uses limit N-1.
// Ports:
//   clk      : clock
//   rst_n    : async active-low reset, count -> 0
//   i_clr    : synchronous clear (wins over enable)
//   i_en     : count enable
//   i_limit  : terminal value
//   o_tc     : count == i_limit
module rst_seq_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_limit,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_tc = (r_count == i_limit);

endmodule

// File: rtl/rst_release_sequencer.sv
// Reset release sequencer for one clock domain.
// Holds NUM_DOMAINS active-low resets asserted for HOLD_CYCLES, then releases
// them one by one (index order) STAGGER_CYCLES apart. A software request
// restarts the whole sequence. All outputs are registered.
// Optional build macro RST_SEQ_CAUSE_EN adds RST_CAUSE and SW_RST_CNT.
// Ports:
//   clk         : clock
//   RST         : async active-low system reset
//   SW_RST_REQ  : synchronous request to re-sequence
//   RST_OUT_N   : active-low domain resets, bit k released k-th
//   BUSY        : high while any RST_OUT_N bit is low
//   DONE        : one-cycle pulse when the last domain is released
//   RST_CAUSE   : (RST_SEQ_CAUSE_EN) 0 = power-on, 1 = software
//   SW_RST_CNT  : (RST_SEQ_CAUSE_EN) saturating count of accepted requests
//
// state     | meaning
// S_HOLD    | all outputs asserted, counting the hold interval
// S_RELEASE | releasing domains 1..N-1, one per stagger interval
// S_RUN     | all domains released, waiting for a software request
module rst_release_sequencer
  import rst_seq_pkg::*;
#(
  parameter int NUM_DOMAINS    = 3,
  parameter int HOLD_CYCLES    = 16,
  parameter int STAGGER_CYCLES = 4,
  parameter int CNT_W          = 8
) (
  input  logic                   clk,
  input  logic                   RST,
  input  logic                   SW_RST_REQ,
  output logic [NUM_DOMAINS-1:0] RST_OUT_N,
  output logic                   BUSY,
  output logic                   DONE
`ifdef RST_SEQ_CAUSE_EN
  ,
  output logic                   RST_CAUSE,
  output logic [SW_CNT_W-1:0]    SW_RST_CNT
`endif
);

  localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAG_LIM = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DOMAINS - 1);

  state_t                 r_state;
  logic [IDX_W-1:0]       r_idx;
  logic [NUM_DOMAINS-1:0] r_rst_out_n;
  logic                   r_busy;
  logic                   r_done;

  logic                   w_tc;
  logic                   w_timer_clr;
  logic                   w_timer_en;
  logic [CNT_W-1:0]       w_limit;
  logic [NUM_DOMAINS-1:0] w_rel_mask;

  // Timer restarts on every interval boundary and on a software request, and
  // parks in RUN so it is at 0 whenever a new hold interval begins.
  assign w_timer_en  = (r_state != S_RUN);
  assign w_timer_clr = SW_RST_REQ | (w_tc & w_timer_en);
  assign w_limit     = (r_state == S_HOLD) ? HOLD_LIM : STAG_LIM;
  assign w_rel_mask  = NUM_DOMAINS'(1) << r_idx;

  rst_seq_timer #(.CNT_W(CNT_W)) u_timer (
    .clk     (clk),
    .rst_n   (RST),
    .i_clr   (w_timer_clr),
    .i_en    (w_timer_en),
    .i_limit (w_limit),
    .o_tc    (w_tc)
  );

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      r_state     <= S_HOLD;
      r_idx       <= '0;
      r_rst_out_n <= '0;
      r_busy      <= 1'b1;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (SW_RST_REQ) begin
        r_state     <= S_HOLD;
        r_idx       <= '0;
        r_rst_out_n <= '0;
        r_busy      <= 1'b1;
      end else begin
        unique case (r_state)
          S_HOLD: begin
            if (w_tc) begin
              r_rst_out_n[0] <= 1'b1;
              if (NUM_DOMAINS == 1) begin
                r_state <= S_RUN;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                r_state <= S_RELEASE;
                r_idx   <= IDX_W'(1);
              end
            end
          end
          S_RELEASE: begin
            if (w_tc) begin
              r_rst_out_n <= r_rst_out_n | w_rel_mask;
              if (r_idx == LAST_IDX) begin
                r_state <= S_RUN;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                r_idx <= r_idx + IDX_W'(1);
              end
            end
          end
          S_RUN: begin
          end
          default: r_state <= S_HOLD;
        endcase
      end
    end
  end

  assign RST_OUT_N = r_rst_out_n;
  assign BUSY      = r_busy;
  assign DONE      = r_done;

`ifdef RST_SEQ_CAUSE_EN
  logic                r_cause;
  logic [SW_CNT_W-1:0] r_sw_cnt;

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      r_cause  <= CAUSE_POR;
      r_sw_cnt <= '0;
    end else if (SW_RST_REQ) begin
      r_cause <= CAUSE_SW;
      if (r_sw_cnt != '1) begin
        r_sw_cnt <= r_sw_cnt + SW_CNT_W'(1);
      end
    end
  end

  assign RST_CAUSE  = r_cause;
  assign SW_RST_CNT = r_sw_cnt;
`endif

endmodule
